// File: rtl/key_load_ctrl_if.sv
// Bit-serial valid/ready link carrying key bits (MSB first, then parity)
// from the test/unlock side into the key-load controller.
interface key_load_ctrl_if;
  logic key_bit;
  logic key_bit_valid;
  logic key_bit_ready;

  // Unlock side drives data/valid and observes ready.
  modport master (
    output key_bit,
    output key_bit_valid,
    input  key_bit_ready
  );

  // Controller side consumes data/valid and drives ready.
  modport slave (
    input  key_bit,
    input  key_bit_valid,
    output key_bit_ready
  );
endinterface

// File: rtl/key_load_ctrl.sv
// Serial key-load sequencer for a logic-locked core. Shifts in KEY_WIDTH key
// bits plus one even-parity bit, commits the key only after the parity bit
// checks out, and only then raises the core's DFF enable.
module key_load_ctrl #(
  parameter int KEY_WIDTH = 32
) (
  input  logic                 CK,
  input  logic                 RST,
  key_load_ctrl_if.slave       bus,
  input  logic                 load_start,
  input  logic                 load_abort,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 key_valid,
  output logic                 core_en,
  output logic                 busy,
  output logic                 load_err
);

  localparam int CNT_W = $clog2(KEY_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(KEY_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PARITY,
    ARMED,
    ERROR
  } state_t;

  state_t               state;
  logic [KEY_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]     cnt;
  logic                 par;
  logic                 ready;
  logic                 accept;

  assign bus.key_bit_ready = ready;
  assign accept            = bus.key_bit_valid & ready;

  // Frame sequencer: all outputs are registered and follow the next state,
  // so key never shows partially shifted bits and core_en tracks key_valid.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      key       <= '0;
      key_valid <= 1'b0;
      core_en   <= 1'b0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      load_err  <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      par       <= 1'b0;
    end else if (load_start) begin
      // Restart from any state: drop whatever key or partial frame was held.
      state     <= LOAD;
      key       <= '0;
      key_valid <= 1'b0;
      core_en   <= 1'b0;
      load_err  <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      par       <= 1'b0;
      ready     <= 1'b1;
      busy      <= 1'b1;
    end else begin
      case (state)
        LOAD, PARITY: begin
          if (load_abort) begin
            // Abandon the frame; key is already 0 and load_err is left alone.
            state <= IDLE;
            ready <= 1'b0;
            busy  <= 1'b0;
            shreg <= '0;
            cnt   <= '0;
            par   <= 1'b0;
          end else if (accept) begin
            if (state == LOAD) begin
              shreg <= {shreg[KEY_WIDTH-2:0], bus.key_bit};
              par   <= par ^ bus.key_bit;
              if (cnt == LAST) begin
                // Counter parks on the last index instead of wrapping.
                state <= PARITY;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              ready <= 1'b0;
              busy  <= 1'b0;
              if (bus.key_bit == par) begin
                // Even total parity: commit key and enable the core together.
                state     <= ARMED;
                key       <= shreg;
                key_valid <= 1'b1;
                core_en   <= 1'b1;
              end else begin
                state     <= ERROR;
                key       <= '0;
                key_valid <= 1'b0;
                core_en   <= 1'b0;
                load_err  <= 1'b1;
              end
            end
          end
        end
        default: begin
          // IDLE, ARMED and ERROR hold until the next load_start.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_load_ctrl.sv
// Bench for key_load_ctrl with an 8-bit key: table-driven frames checked
// through a scoreboard queue, plus hand-written restart/abort/reset sequences.
module tb_key_load_ctrl;

  localparam int KW = 8;

  logic          CK = 1'b0;
  logic          RST;
  logic          load_start;
  logic          load_abort;
  logic [KW-1:0] key;
  logic          key_valid;
  logic          core_en;
  logic          busy;
  logic          load_err;

  key_load_ctrl_if bus();

  key_load_ctrl #(.KEY_WIDTH(KW)) dut (
    .CK        (CK),
    .RST       (RST),
    .bus       (bus),
    .load_start(load_start),
    .load_abort(load_abort),
    .key       (key),
    .key_valid (key_valid),
    .core_en   (core_en),
    .busy      (busy),
    .load_err  (load_err)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic [7:0] k;
    logic       p;
    logic       gap;
    logic [7:0] exp_key;
    logic       exp_kv;
    logic       exp_err;
  } vec_t;

  vec_t vecs[7];
  vec_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic gap);
    if (gap) begin
      bus.key_bit_valid = 1'b0;
      tick();
    end
    bus.key_bit       = b;
    bus.key_bit_valid = 1'b1;
    tick();
    bus.key_bit_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] k, input logic p, input int n, input logic gap);
    logic [8:0] f;
    f = {k, p};
    for (int i = 0; i < n; i++) send_bit(f[8-i], gap);
  endtask

  // Pop the oldest expectation and compare it to what the DUT presents now,
  // i.e. the cycle right after the parity-bit accept.
  task automatic sb_check();
    vec_t v;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      v = sb.pop_front();
      check("frame_busy",     32'(busy),      32'd0);
      check("frame_key",      32'(key),       32'(v.exp_key));
      check("frame_key_valid", 32'(key_valid), 32'(v.exp_kv));
      check("frame_core_en",  32'(core_en),   32'(v.exp_kv));
      check("frame_load_err", 32'(load_err),  32'(v.exp_err));
      check("frame_ready",    32'(bus.key_bit_ready), 32'd0);
    end
  endtask

  task automatic run_frame(input vec_t v);
    start();
    sb.push_back(v);
    send_bits(v.k, v.p, 9, v.gap);
    sb_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         key    par   gap   exp_key kv    err
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h81, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};

    RST               = 1'b1;
    load_start        = 1'b0;
    load_abort        = 1'b0;
    bus.key_bit       = 1'b0;
    bus.key_bit_valid = 1'b0;

    // Reset state, observed before any clock edge.
    #2;
    check("rst_key",       32'(key),                32'd0);
    check("rst_key_valid", 32'(key_valid),          32'd0);
    check("rst_core_en",   32'(core_en),            32'd0);
    check("rst_busy",      32'(busy),               32'd0);
    check("rst_ready",     32'(bus.key_bit_ready),  32'd0);
    check("rst_load_err",  32'(load_err),           32'd0);
    tick();
    tick();
    RST = 1'b0;
    tick();
    check("idle_ready", 32'(bus.key_bit_ready), 32'd0);

    // Table-driven frames.
    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // Bad frame, then restart clears load_err on the next cycle; good frame commits.
    run_frame(vecs[1]);
    start();
    check("restart_load_err", 32'(load_err),           32'd0);
    check("restart_busy",     32'(busy),               32'd1);
    check("restart_ready",    32'(bus.key_bit_ready),  32'd1);
    send_bits(8'h3C, 1'b0, 9, 1'b0);
    check("after_err_key",    32'(key),                32'h3C);
    check("after_err_kv",     32'(key_valid),          32'd1);

    // From ARMED: restart clears key at once, then abort after 3 bits.
    run_frame(vecs[0]);
    start();
    check("armed_restart_key",   32'(key),               32'd0);
    check("armed_restart_kv",    32'(key_valid),         32'd0);
    check("armed_restart_coren", 32'(core_en),           32'd0);
    check("armed_restart_ready", 32'(bus.key_bit_ready), 32'd1);
    send_bits(8'hA5, 1'b0, 3, 1'b0);
    check("partial_key",         32'(key),               32'd0);
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    check("abort_busy",  32'(busy),               32'd0);
    check("abort_ready", 32'(bus.key_bit_ready),  32'd0);
    check("abort_key",   32'(key),                32'd0);
    check("abort_kv",    32'(key_valid),          32'd0);

    // Abort is ignored once ARMED.
    run_frame(vecs[0]);
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    check("armed_abort_kv",  32'(key_valid), 32'd1);
    check("armed_abort_key", 32'(key),       32'hA5);

    // Abort in ERROR leaves the sticky error flag set.
    run_frame(vecs[5]);
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    check("err_abort_load_err", 32'(load_err), 32'd1);

    // Async reset mid-LOAD: outputs clear between clock edges.
    start();
    send_bits(8'hA5, 1'b0, 5, 1'b0);
    RST = 1'b1;
    #2;
    check("amid_rst_busy",  32'(busy),               32'd0);
    check("amid_rst_ready", 32'(bus.key_bit_ready),  32'd0);
    check("amid_rst_key",   32'(key),                32'd0);
    check("amid_rst_kv",    32'(key_valid),          32'd0);
    check("amid_rst_coren", 32'(core_en),            32'd0);
    check("amid_rst_err",   32'(load_err),           32'd0);
    tick();
    RST = 1'b0;
    tick();
    run_frame(vecs[2]);

    // load_start and load_abort together mid-frame: restart wins, count restarts.
    start();
    send_bits(8'hA5, 1'b0, 2, 1'b0);
    load_start = 1'b1;
    load_abort = 1'b1;
    tick();
    load_start = 1'b0;
    load_abort = 1'b0;
    check("both_busy",  32'(busy),               32'd1);
    check("both_ready", 32'(bus.key_bit_ready),  32'd1);
    send_bits(8'h5A, 1'b0, 8, 1'b0);
    check("both_8bits_busy", 32'(busy),      32'd1);
    check("both_8bits_kv",   32'(key_valid), 32'd0);
    send_bit(1'b0, 1'b0);
    check("both_commit_kv",  32'(key_valid), 32'd1);
    check("both_commit_key", 32'(key),       32'h5A);
    check("both_commit_err", 32'(load_err),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
